// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite channel bundle used for both requester ports and the downstream bus
// of axi_lite_arbiter.
`timescale 1ns/1ps
interface axi_intf #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-requester round-robin AXI4-Lite arbiter, one transaction outstanding at a time.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module axi_lite_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       aclk,
    input  logic       aresetn,
    axi_intf.slave     s0,
    axi_intf.slave     s1,
    axi_intf.master    m,
    output logic [1:0] grant,
    output logic       busy
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, ERR} state_t;

    state_t        state;
    logic          aw_done;
    logic          w_done;
    logic          prio;
    logic          is_wr;
    logic [TW-1:0] tcnt;
    logic          tmo_hit;

    logic s0_wr, s0_rd, s1_wr, s1_rd, s0_req, s1_req, pick1, pick_wr;

    logic                    sel;
    logic [ADDR_WIDTH-1:0]   g_awaddr;
    logic [ADDR_WIDTH-1:0]   g_araddr;
    logic [DATA_WIDTH-1:0]   g_wdata;
    logic [DATA_WIDTH/8-1:0] g_wstrb;
    logic                    g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

    logic                  up_awready, up_wready, up_bvalid, up_arready, up_rvalid;
    logic [1:0]            up_bresp, up_rresp;
    logic [DATA_WIDTH-1:0] up_rdata;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    assign s0_wr  = s0.awvalid && s0.wvalid;
    assign s0_rd  = s0.arvalid;
    assign s1_wr  = s1.awvalid && s1.wvalid;
    assign s1_rd  = s1.arvalid;
    assign s0_req = s0_wr || s0_rd;
    assign s1_req = s1_wr || s1_rd;
    assign pick1  = s1_req && (!s0_req || prio);
    assign pick_wr = pick1 ? s1_wr : s0_wr;

    assign sel       = grant[1];
    assign g_awaddr  = sel ? s1.awaddr  : s0.awaddr;
    assign g_araddr  = sel ? s1.araddr  : s0.araddr;
    assign g_wdata   = sel ? s1.wdata   : s0.wdata;
    assign g_wstrb   = sel ? s1.wstrb   : s0.wstrb;
    assign g_awvalid = sel ? s1.awvalid : s0.awvalid;
    assign g_wvalid  = sel ? s1.wvalid  : s0.wvalid;
    assign g_bready  = sel ? s1.bready  : s0.bready;
    assign g_arvalid = sel ? s1.arvalid : s0.arvalid;
    assign g_rready  = sel ? s1.rready  : s0.rready;

    always_comb begin
        m.awaddr   = '0;
        m.awvalid  = 1'b0;
        m.wdata    = '0;
        m.wstrb    = '0;
        m.wvalid   = 1'b0;
        m.bready   = 1'b0;
        m.araddr   = '0;
        m.arvalid  = 1'b0;
        m.rready   = 1'b0;
        up_awready = 1'b0;
        up_wready  = 1'b0;
        up_bvalid  = 1'b0;
        up_bresp   = '0;
        up_arready = 1'b0;
        up_rvalid  = 1'b0;
        up_rdata   = '0;
        up_rresp   = '0;
        if (state != IDLE) begin
            m.awaddr = g_awaddr;
            m.wdata  = g_wdata;
            m.wstrb  = g_wstrb;
            m.araddr = g_araddr;
        end
        case (state)
            WADDR: begin
                m.awvalid  = g_awvalid && !aw_done;
                m.wvalid   = g_wvalid && !w_done;
                up_awready = m.awready && !aw_done;
                up_wready  = m.wready && !w_done;
            end
            WRESP: begin
                m.bready  = g_bready;
                up_bvalid = m.bvalid;
                up_bresp  = m.bresp;
            end
            RADDR: begin
                m.arvalid  = g_arvalid;
                up_arready = m.arready;
            end
            RDATA: begin
                m.rready  = g_rready;
                up_rvalid = m.rvalid;
                up_rdata  = m.rdata;
                up_rresp  = m.rresp;
            end
            ERR: begin
                // Synthesised SLVERR; downstream is drained in case a late response shows up.
                m.bready  = 1'b1;
                m.rready  = 1'b1;
                up_bvalid = is_wr;
                up_rvalid = !is_wr;
                up_bresp  = is_wr ? 2'b10 : 2'b00;
                up_rresp  = is_wr ? 2'b00 : 2'b10;
            end
            default: ;
        endcase
    end

    assign s0.awready = grant[0] && up_awready;
    assign s0.wready  = grant[0] && up_wready;
    assign s0.bvalid  = grant[0] && up_bvalid;
    assign s0.bresp   = grant[0] ? up_bresp : '0;
    assign s0.arready = grant[0] && up_arready;
    assign s0.rvalid  = grant[0] && up_rvalid;
    assign s0.rdata   = grant[0] ? up_rdata : '0;
    assign s0.rresp   = grant[0] ? up_rresp : '0;
    assign s1.awready = grant[1] && up_awready;
    assign s1.wready  = grant[1] && up_wready;
    assign s1.bvalid  = grant[1] && up_bvalid;
    assign s1.bresp   = grant[1] ? up_bresp : '0;
    assign s1.arready = grant[1] && up_arready;
    assign s1.rvalid  = grant[1] && up_rvalid;
    assign s1.rdata   = grant[1] ? up_rdata : '0;
    assign s1.rresp   = grant[1] ? up_rresp : '0;

    assign aw_hs   = m.awvalid && m.awready;
    assign w_hs    = m.wvalid && m.wready;
    assign ar_hs   = m.arvalid && m.arready;
    assign b_hs    = up_bvalid && g_bready;
    assign r_hs    = up_rvalid && g_rready;
    assign tmo_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state   <= IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            prio    <= 1'b0;
            is_wr   <= 1'b0;
            tcnt    <= '0;
        end else if (b_hs || r_hs) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            prio  <= grant[0];
        end else begin
            case (state)
                IDLE: begin
                    if (s0_req || s1_req) begin
                        grant <= pick1 ? 2'b10 : 2'b01;
                        busy  <= 1'b1;
                        is_wr <= pick_wr;
                        state <= pick_wr ? WADDR : RADDR;
                    end
                end
                WADDR: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state   <= WRESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        tcnt    <= '0;
                    end else begin
                        aw_done <= aw_done || aw_hs;
                        w_done  <= w_done || w_hs;
                    end
                end
                RADDR: begin
                    if (ar_hs) begin
                        state <= RDATA;
                        tcnt  <= '0;
                    end
                end
                WRESP, RDATA: begin
                    // The wait counter saturates in both builds; only the watchdog build acts on it.
                    if (!((state == WRESP) ? m.bvalid : m.rvalid)) begin
                        if (!tmo_hit) tcnt <= tcnt + TW'(1);
`ifdef ARB_TIMEOUT_EN
                        else state <= ERR;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter: arbitration order, write/read
// forwarding, split AW/W acceptance, reset abort and the response watchdog.
`timescale 1ns/1ps
module tb_axi_lite_arbiter;
    logic       aclk;
    logic       aresetn;
    logic [1:0] grant;
    logic       busy;
    int         n_chk;
    int         n_fail;

    axi_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0_if ();
    axi_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s1_if ();
    axi_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

    axi_lite_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .s0     (s0_if.slave),
        .s1     (s1_if.slave),
        .m      (m_if.master),
        .grant  (grant),
        .busy   (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        aresetn = 1'b0;
        s0_if.awaddr = '0; s0_if.awvalid = 0; s0_if.wdata = '0; s0_if.wstrb = 4'hF;
        s0_if.wvalid = 0; s0_if.bready = 1; s0_if.araddr = '0; s0_if.arvalid = 0; s0_if.rready = 1;
        s1_if.awaddr = '0; s1_if.awvalid = 0; s1_if.wdata = '0; s1_if.wstrb = 4'hF;
        s1_if.wvalid = 0; s1_if.bready = 1; s1_if.araddr = '0; s1_if.arvalid = 0; s1_if.rready = 1;
        m_if.awready = 0; m_if.wready = 0; m_if.bresp = '0; m_if.bvalid = 0;
        m_if.arready = 0; m_if.rdata = '0; m_if.rresp = '0; m_if.rvalid = 0;

        // reset
        adv(); adv();
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        aresetn = 1'b1;
        adv();
        chk("post_rst_m_awvalid", m_if.awvalid, 1'b0);
        chk("post_rst_m_arvalid", m_if.arvalid, 1'b0);
        chk("post_rst_s0_bvalid", s0_if.bvalid, 1'b0);

        // both read together: s0 wins on initial priority
        s0_if.arvalid = 1; s0_if.araddr = 32'h100;
        s1_if.arvalid = 1; s1_if.araddr = 32'h200;
        #1;
        chk("idle_s0_arready", s0_if.arready, 1'b0);
        chk("idle_m_arvalid", m_if.arvalid, 1'b0);
        adv();
        chk("rr1_grant", grant, 2'b01);
        chk("rr1_araddr", m_if.araddr, 32'h100);
        chk("rr1_arvalid", m_if.arvalid, 1'b1);
        m_if.arready = 1; #1;
        chk("rr1_s0_arready", s0_if.arready, 1'b1);
        chk("rr1_s1_arready", s1_if.arready, 1'b0);
        adv();
        s0_if.arvalid = 0; m_if.arready = 0;
        m_if.rvalid = 1; m_if.rdata = 32'hAAAA; #1;
        chk("rr1_s0_rvalid", s0_if.rvalid, 1'b1);
        chk("rr1_s0_rdata", s0_if.rdata, 32'hAAAA);
        chk("rr1_s1_rvalid", s1_if.rvalid, 1'b0);
        chk("rr1_m_rready", m_if.rready, 1'b1);
        adv();
        m_if.rvalid = 0;
        s0_if.arvalid = 1; s0_if.araddr = 32'h104;
        #1;
        chk("rr1_idle_busy", busy, 1'b0);
        chk("rr1_idle_grant", grant, 2'b00);
        // both request again: s1 now holds priority
        adv();
        chk("rr2_grant", grant, 2'b10);
        chk("rr2_araddr", m_if.araddr, 32'h200);
        m_if.arready = 1;
        adv();
        s1_if.arvalid = 0; m_if.arready = 0;
        m_if.rvalid = 1; m_if.rdata = 32'hBBBB; #1;
        chk("rr2_s1_rdata", s1_if.rdata, 32'hBBBB);
        chk("rr2_s0_rvalid", s0_if.rvalid, 1'b0);
        adv();
        m_if.rvalid = 0;
        adv();
        chk("rr3_grant", grant, 2'b01);
        chk("rr3_araddr", m_if.araddr, 32'h104);
        m_if.arready = 1;
        adv();
        s0_if.arvalid = 0; m_if.arready = 0;
        m_if.rvalid = 1; m_if.rdata = 32'hCCCC; #1;
        chk("rr3_s0_rdata", s0_if.rdata, 32'hCCCC);
        adv();
        m_if.rvalid = 0;

        // single s0 write
        s0_if.awvalid = 1; s0_if.awaddr = 32'hFF; s0_if.wvalid = 1; s0_if.wdata = 32'h5;
        adv();
        chk("w_grant", grant, 2'b01);
        chk("w_busy", busy, 1'b1);
        chk("w_awaddr", m_if.awaddr, 32'hFF);
        chk("w_wdata", m_if.wdata, 32'h5);
        chk("w_awvalid", m_if.awvalid, 1'b1);
        chk("w_wvalid", m_if.wvalid, 1'b1);
        m_if.awready = 1; m_if.wready = 1; #1;
        chk("w_s0_awready", s0_if.awready, 1'b1);
        chk("w_s1_awready", s1_if.awready, 1'b0);
        adv();
        s0_if.awvalid = 0; s0_if.wvalid = 0; m_if.awready = 0; m_if.wready = 0;
        m_if.bvalid = 1; m_if.bresp = 2'b00; #1;
        chk("w_resp_grant", grant, 2'b01);
        chk("w_s0_bvalid", s0_if.bvalid, 1'b1);
        chk("w_s0_bresp", s0_if.bresp, 2'b00);
        chk("w_m_bready", m_if.bready, 1'b1);
        adv();
        m_if.bvalid = 0; #1;
        chk("w_done_busy", busy, 1'b0);
        chk("w_idle_awaddr", m_if.awaddr, 32'h0);

        // s1 write and read together: write goes first
        s1_if.awvalid = 1; s1_if.awaddr = 32'h300; s1_if.wvalid = 1; s1_if.wdata = 32'h33;
        s1_if.arvalid = 1; s1_if.araddr = 32'h400;
        adv();
        chk("wr_grant", grant, 2'b10);
        chk("wr_awvalid", m_if.awvalid, 1'b1);
        chk("wr_no_ar", m_if.arvalid, 1'b0);
        chk("wr_no_arready", s1_if.arready, 1'b0);
        m_if.awready = 1; m_if.wready = 1;
        adv();
        s1_if.awvalid = 0; s1_if.wvalid = 0; m_if.awready = 0; m_if.wready = 0;
        m_if.bvalid = 1; #1;
        chk("wr_resp_no_ar", m_if.arvalid, 1'b0);
        chk("wr_s1_bvalid", s1_if.bvalid, 1'b1);
        adv();
        m_if.bvalid = 0;
        adv();
        chk("wr_rd_arvalid", m_if.arvalid, 1'b1);
        chk("wr_rd_araddr", m_if.araddr, 32'h400);
        m_if.arready = 1;
        adv();
        s1_if.arvalid = 0; m_if.arready = 0; m_if.rvalid = 1; m_if.rdata = 32'h44;
        adv();
        m_if.rvalid = 0;

        // downstream takes W three cycles before AW
        s0_if.awvalid = 1; s0_if.awaddr = 32'h500; s0_if.wvalid = 1; s0_if.wdata = 32'h55;
        adv();
        m_if.wready = 1; #1;
        chk("split_wready", s0_if.wready, 1'b1);
        chk("split_awready", s0_if.awready, 1'b0);
        adv();
        chk("split_no_dup_w1", m_if.wvalid, 1'b0);
        chk("split_awvalid", m_if.awvalid, 1'b1);
        adv();
        chk("split_no_dup_w2", m_if.wvalid, 1'b0);
        adv();
        m_if.awready = 1; #1;
        chk("split_s0_awready", s0_if.awready, 1'b1);
        chk("split_s0_wready_masked", s0_if.wready, 1'b0);
        adv();
        s0_if.awvalid = 0; s0_if.wvalid = 0; m_if.awready = 0; m_if.wready = 0; #1;
        chk("split_wresp_bready", m_if.bready, 1'b1);
        chk("split_wresp_awvalid", m_if.awvalid, 1'b0);
        m_if.bvalid = 1;
        adv();
        m_if.bvalid = 0;

        // reset while waiting for read data
        s1_if.arvalid = 1; s1_if.araddr = 32'h600;
        adv();
        m_if.arready = 1;
        adv();
        s1_if.arvalid = 0; m_if.arready = 0; #1;
        chk("rrst_rready", m_if.rready, 1'b1);
        aresetn = 1'b0;
        adv();
        aresetn = 1'b1;
        m_if.rvalid = 1; m_if.rdata = 32'hDEAD; #1;
        chk("rrst_busy", busy, 1'b0);
        chk("rrst_grant", grant, 2'b00);
        chk("rrst_s1_rvalid", s1_if.rvalid, 1'b0);
        chk("rrst_s0_rvalid", s0_if.rvalid, 1'b0);
        m_if.rvalid = 0;
        s0_if.arvalid = 1; s0_if.araddr = 32'h700;
        adv();
        chk("rrst_new_grant", grant, 2'b01);
        m_if.arready = 1;
        adv();
        s0_if.arvalid = 0; m_if.arready = 0; m_if.rvalid = 1; m_if.rdata = 32'h77; #1;
        chk("rrst_new_rvalid", s0_if.rvalid, 1'b1);
        chk("rrst_new_rdata", s0_if.rdata, 32'h77);
        adv();
        m_if.rvalid = 0; #1;
        chk("rrst_new_idle", busy, 1'b0);

        // downstream withholds the write response
        s0_if.awvalid = 1; s0_if.awaddr = 32'h800; s0_if.wvalid = 1; s0_if.wdata = 32'h88;
        adv();
        m_if.awready = 1; m_if.wready = 1;
        adv();
        s0_if.awvalid = 0; s0_if.wvalid = 0; m_if.awready = 0; m_if.wready = 0;
`ifdef ARB_TIMEOUT_EN
        adv(); adv(); adv();
        chk("tmo_wait_bvalid", s0_if.bvalid, 1'b0);
        adv();
        chk("tmo_err_bvalid", s0_if.bvalid, 1'b1);
        chk("tmo_err_bresp", s0_if.bresp, 2'b10);
        chk("tmo_err_bready", m_if.bready, 1'b1);
        chk("tmo_err_rready", m_if.rready, 1'b1);
        adv();
        chk("tmo_idle_busy", busy, 1'b0);
        chk("tmo_idle_grant", grant, 2'b00);
`else
        for (int i = 0; i < 10; i++) adv();
        chk("hold_busy", busy, 1'b1);
        chk("hold_bvalid", s0_if.bvalid, 1'b0);
        m_if.bvalid = 1; m_if.bresp = 2'b01; #1;
        chk("hold_late_bvalid", s0_if.bvalid, 1'b1);
        chk("hold_late_bresp", s0_if.bresp, 2'b01);
        adv();
        m_if.bvalid = 0; #1;
        chk("hold_idle_busy", busy, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning address width of all AXI ports.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning data width of all AXI ports.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning response watchdog limit in cycles (used only with REQ-030).
REQ-004 The block SHALL have port aclk  input  1  single clock for all logic.
REQ-005 The block SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port s0  axi_intf.slave  -  requester 0 (fixed initial priority).
REQ-007 The block SHALL have port s1  axi_intf.slave  -  requester 1.
REQ-008 The block SHALL have port m  axi_intf.master  -  shared downstream peripheral bus.
REQ-009 The block SHALL have port grant  output  2  one-hot granted requester; 2'b00 when idle.
REQ-010 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-011 The block SHALL use states IDLE, WADDR, WRESP, RADDR, RDATA (plus ERR, see REQ-030), with one AXI-lite transaction outstanding at a time.
REQ-012 Write request of sN SHALL be awvalid && wvalid; read request SHALL be arvalid.
REQ-013 In IDLE, all s0/s1 ready/valid outputs and all m valid/ready outputs SHALL be 0.
REQ-014 In IDLE, if any request exists, the block SHALL register a grant and move next cycle to WADDR (write) or RADDR (read); minimum latency request-to-forward: 1 cycle.
REQ-015 Between requesters, the requester holding round-robin priority SHALL win when both request in the same cycle; otherwise the sole requester SHALL win.
REQ-016 Within one requester, a write request SHALL win over a simultaneous read request.
REQ-017 On completion of any transaction by sK, priority SHALL pass to the other requester.
REQ-018 In WADDR, AW and W SHALL be forwarded independently: m.awvalid = sG.awvalid && !aw_done, sG.awready = m.awready && !aw_done; identically for W with w_done.
REQ-019 WADDR SHALL move to WRESP in the cycle both AW and W handshakes have completed, including both in the same cycle.
REQ-020 In WRESP, bvalid/bresp SHALL pass m->sG and bready sG->m; on the B handshake the state SHALL return to IDLE.
REQ-021 In RADDR, AR SHALL be forwarded; on the AR handshake the state SHALL move to RDATA.
REQ-022 In RDATA, rvalid/rdata/rresp SHALL pass m->sG and rready sG->m; on the R handshake the state SHALL return to IDLE.
REQ-023 The non-granted requester SHALL see all ready and valid signals 0 and SHALL keep its request pending without loss.
REQ-024 m address/data outputs SHALL be driven from the granted requester; in IDLE they SHALL be 0.
REQ-025 grant SHALL be stable from leaving IDLE until returning to IDLE.

Reset
REQ-026 While aresetn is low at a rising aclk edge, state SHALL become IDLE, grant 2'b00, busy 0, aw_done/w_done 0, priority s0.
REQ-027 Reset mid-transaction SHALL discard the transaction; no response SHALL be returned to either requester.
REQ-028 All valid/ready outputs SHALL be 0 in the first cycle after reset.

Configuration
REQ-029 Without ARB_TIMEOUT_EN, WRESP and RDATA SHALL wait indefinitely for the downstream response.
REQ-030 With ARB_TIMEOUT_EN defined, a counter SHALL clear on entering WRESP/RDATA and, after TIMEOUT_CYCLES cycles without m.bvalid/m.rvalid, the state SHALL move to ERR.
REQ-031 In ERR the block SHALL drive sG.bvalid (write) or sG.rvalid (read) with resp 2'b10 and rdata 0, hold m.bready = m.rready = 1 to drain stray responses, return to IDLE on the requester handshake, and pass priority as in REQ-017.

Verification
REQ-032 s0 write awaddr 0xFF wdata 0x5 alone -> m.awaddr 0xFF, m.wdata 0x5 one cycle after request; s0 gets bresp 0; grant 2'b01 throughout.
REQ-033 s0 and s1 both issue reads in the same cycle after reset -> s0 served first, then s1; repeat -> s1 served first.
REQ-034 s1 write plus read simultaneously -> write completes (B handshake) before AR appears on m.
REQ-035 Downstream accepts W 3 cycles before AW -> single write forwarded, no duplicate W, WRESP entered in the AW handshake cycle.
REQ-036 aresetn low during RDATA -> next cycle busy 0, grant 2'b00, no rvalid to requester; a new read then completes normally.
REQ-037 With ARB_TIMEOUT_EN, TIMEOUT_CYCLES 4, slave never asserts bvalid -> requester receives bresp 2'b10 after 4 cycles in WRESP; block returns to IDLE.
